mult_div_unit: RTL and testbench

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It answers the `start`/`busy` handshake that the hazard unit samples: while `start || busy`, the hazard unit stalls any HI/LO-class instruction in D. The unit owns the HI/LO registers, runs multi-cycle mult/div operations, and supports flushing a launch when an exception or interrupt is taken.

---
 rtl/mult_div_unit_pkg.sv | 44 ++++
 rtl/mult_div_unit_calc.sv | 63 ++++++
 rtl/mult_div_unit.sv | 113 +++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared md_op encodings, default latencies and FSM state type.
// MD_MADD_EN enables the madd/maddu/msub/msubu launch opcodes.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MADD  = 4'd4,
        MD_MADDU = 4'd5,
        MD_MSUB  = 4'd6,
        MD_MSUBU = 4'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    function automatic logic md_op_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Opcodes that actually start a multi-cycle operation.
    function automatic logic md_op_launches(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: ok = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: ok = 1'b1;
`else
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational mult/div/madd result for the latched operands.
// Produces the full {HI,LO} value and a divide-by-zero flag.
module md_result_calc
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        b_zero;
    logic [31:0] b_safe;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;

    assign b_zero   = (b == 32'd0);
    assign div_zero = md_op_is_div(op) && b_zero;
    assign b_safe   = b_zero ? 32'd1 : b;

    // Sign-magnitude divide; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign abs_a = a[31] ? (32'd0 - a) : a;
    assign abs_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign q_mag = abs_a / abs_b;
    assign r_mag = abs_a % abs_b;
    assign q_s   = (a[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

    assign q_u = a / b_safe;
    assign r_u = a % b_safe;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign acc    = {hi, lo};

    always_comb begin
        result = acc;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {r_s, q_s};
            MD_DIVU:  result = {r_u, q_u};
            MD_MADD:  result = acc + prod_s;
            MD_MADDU: result = acc + prod_u;
            MD_MSUB:  result = acc - prod_s;
            MD_MSUBU: result = acc - prod_u;
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: launch FSM, latency counter and HI/LO.
// madd-class launches depend on MD_MADD_EN (see mult_div_unit_pkg).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      hi_q;
    logic [31:0]      hi_d;
    logic [31:0]      lo_q;
    logic [31:0]      lo_d;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             latch_en;
    logic [63:0]      result;
    logic             div_zero;

    md_result_calc u_calc (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .result   (result),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (latch_en) begin
                op_q <= md_op;
                a_q  <= rs;
                b_q  <= rt;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        latch_en = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                // Any start (even a no-op opcode) drops a same-cycle mt*.
                if (start && !flush) begin
                    if (md_op_launches(md_op)) begin
                        latch_en = 1'b1;
                        state_d  = MD_RUN;
                        count_d  = md_op_is_div(md_op) ? CNT_W'(DIV_CYCLES)
                                                       : CNT_W'(MULT_CYCLES);
                    end
                end else if (!start && !flush) begin
                    if (hi_we) hi_d = rs;
                    if (lo_we) lo_d = rs;
                end
            end
            MD_RUN: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (!div_zero) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy = (state_q == MD_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an
// arithmetic reference model of HI/LO and busy latency.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .rs      (rs),
        .rt      (rt),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one launch on the model HI/LO.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] p, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        cyc = 0;
        case (op)
            4'd0: begin p = sa * sb; {m_hi, m_lo} = p; cyc = MC; end
            4'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p; cyc = MC;
            end
            4'd2: begin
                cyc = DC;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            4'd3: begin
                cyc = DC;
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            end
`ifdef MD_MADD_EN
            4'd4: begin p = sa * sb; {m_hi, m_lo} = acc + p; cyc = MC; end
            4'd5: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = acc + p; cyc = MC;
            end
            4'd6: begin p = sa * sb; {m_hi, m_lo} = acc - p; cyc = MC; end
            4'd7: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = acc - p; cyc = MC;
            end
`endif
            default: cyc = 0;
        endcase
    endtask

    // Launch and track busy; optional flush / dropped mtlo at cycle T+k.
    task automatic launch(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at,
                          input int mt_at, input logic with_mt);
        int cyc, n;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; md_op = op; rs = a; rt = b;
        lo_we = with_mt;
        model(op, a, b, cyc);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0; lo_we = 1'b0;
            if (!busy) break;
            n++;
            if (i == flush_at) flush = 1'b1;
            if (i == mt_at) begin lo_we = 1'b1; rs = 32'h0000abcd; end
        end
        check("busy_cycles", n, cyc);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] v,
                      input logic fl);
        @(negedge clk);
        hi_we = h; lo_we = l; rs = v; flush = fl;
        if (!fl && h) m_hi = v;
        if (!fl && l) m_lo = v;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'hffffffff;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset_n = 1'b1;

        launch(MD_MULT, 32'hfffffffe, 32'd3, -1, -1, 1'b0);
        launch(MD_MULTU, 32'hfffffffe, 32'd3, -1, -1, 1'b0);
        launch(MD_DIV, 32'hfffffff9, 32'd2, -1, -1, 1'b0);
        launch(MD_DIVU, 32'd7, 32'd0, -1, -1, 1'b0);
        launch(MD_DIV, 32'h80000000, 32'hffffffff, -1, -1, 1'b0);

        // start together with flush is discarded
        @(negedge clk);
        start = 1'b1; flush = 1'b1; md_op = MD_MULT;
        rs = 32'd9; rt = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("sf_busy", {31'd0, busy}, 32'd0);
        check("sf_hi", hi, m_hi);
        check("sf_lo", lo, m_lo);

        launch(MD_MULT, 32'd1234, 32'd5678, 2, -1, 1'b0);
        mt(1'b1, 1'b0, 32'h12345678, 1'b0);
        launch(MD_MULTU, 32'd77, 32'd3, -1, 2, 1'b0);
        mt(1'b0, 1'b1, 32'h55aa55aa, 1'b1);
        launch(MD_MULT, 32'd6, 32'd7, -1, -1, 1'b1);

        // asynchronous reset in the middle of a divide
        mt(1'b1, 1'b1, 32'hdeadbeef, 1'b0);
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; rs = 32'd100; rt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        launch(MD_MULT, 32'd11, 32'hfffffff0, -1, -1, 1'b0);

        mt(1'b1, 1'b1, 32'd0, 1'b0);
        mt(1'b0, 1'b1, 32'hffffffff, 1'b0);
        launch(MD_MADD, 32'd1, 32'd1, -1, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                mt(1'($urandom), 1'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0));
            launch(4'($urandom_range(0, 7)), pick(), pick(),
                   ($urandom_range(0, 3) == 0) ? 2 : -1,
                   ($urandom_range(0, 3) == 0) ? 3 : -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
